// File: rtl/fdd_seek_ctrl.sv
// Floppy head positioner: RESTORE/SEEK/STEP_IN/STEP_OUT with timed step pulses and head settle.
// Accepts a command only when cmd_ready (IDLE); reports completion with a one-clk done plus a held error flag.
module fdd_seek_ctrl #(
    parameter int STEP_MS       = 4,
    parameter int SETTLE_MS     = 15,
    parameter int PULSE_CLKS    = 4,
    parameter int MAX_TRACKS    = 80,
    parameter int RESTORE_LIMIT = 84
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       msclk,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [6:0] target,
    input  logic       abort,
    input  logic       TRACK0n,
    output logic       STEPn,
    output logic       SDIRn,
    output logic [6:0] cur_track,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_DIR, S_PULSE, S_STEP_WAIT, S_SETTLE, S_FINISH
    } state_t;

    localparam logic [1:0]  CMD_RESTORE  = 2'd0;
    localparam logic [1:0]  CMD_SEEK     = 2'd1;
    localparam logic [1:0]  CMD_STEP_IN  = 2'd2;
    localparam logic [1:0]  CMD_STEP_OUT = 2'd3;
    localparam logic [6:0]  LP_MAX       = 7'(MAX_TRACKS);
    localparam logic [7:0]  LP_LIMIT     = 8'(RESTORE_LIMIT);
    localparam logic [15:0] LP_STEP      = 16'(STEP_MS);
    localparam logic [15:0] LP_SETTLE    = 16'(SETTLE_MS);
    localparam logic [15:0] LP_PULSE     = 16'(PULSE_CLKS - 1);

    state_t      r_state, w_next_state;
    logic [1:0]  r_cmd;
    logic [6:0]  r_target;
    logic [6:0]  r_cur_track, w_track_nxt;
    logic        r_sdir, w_sdir_nxt;
    logic        r_error, w_error_nxt;
    logic        r_ready;
    logic [7:0]  r_restore_cnt, w_restore_cnt_nxt;
    logic [15:0] r_pulse_cnt, w_pulse_cnt_nxt;
    logic [15:0] r_ms_cnt, w_ms_cnt_nxt;
    logic        w_accept;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_cmd         <= 2'd0;
            r_target      <= 7'd0;
            r_cur_track   <= 7'd0;
            r_sdir        <= 1'b0;
            r_error       <= 1'b0;
            r_ready       <= 1'b0;
            r_restore_cnt <= 8'd0;
            r_pulse_cnt   <= 16'd0;
            r_ms_cnt      <= 16'd0;
        end else begin
            r_state       <= w_next_state;
            r_cur_track   <= w_track_nxt;
            r_sdir        <= w_sdir_nxt;
            r_error       <= w_error_nxt;
            r_ready       <= 1'b1;
            r_restore_cnt <= w_restore_cnt_nxt;
            r_pulse_cnt   <= w_pulse_cnt_nxt;
            r_ms_cnt      <= w_ms_cnt_nxt;
            if (w_accept) begin
                r_cmd    <= cmd;
                r_target <= target;
            end
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_track_nxt       = r_cur_track;
        w_sdir_nxt        = r_sdir;
        w_error_nxt       = r_error;
        w_restore_cnt_nxt = r_restore_cnt;
        w_pulse_cnt_nxt   = r_pulse_cnt;
        w_ms_cnt_nxt      = r_ms_cnt;
        w_accept          = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid && r_ready) begin
                    w_accept          = 1'b1;
                    w_next_state      = S_CHECK;
                    w_error_nxt       = 1'b0;
                    w_restore_cnt_nxt = 8'd0;
                end
            end
            S_CHECK: begin
                case (r_cmd)
                    CMD_SEEK: begin
                        if (r_target > LP_MAX) begin
                            w_next_state = S_FINISH;
                            w_error_nxt  = 1'b1;
                        end else if (r_target == r_cur_track) begin
                            w_next_state = S_FINISH;
                        end else begin
                            w_sdir_nxt   = (r_target > r_cur_track);
                            w_next_state = S_DIR;
                        end
                    end
                    CMD_STEP_IN: begin
                        if (r_cur_track == LP_MAX) begin
                            w_next_state = S_FINISH;
                            w_error_nxt  = 1'b1;
                        end else begin
                            w_sdir_nxt   = 1'b1;
                            w_next_state = S_DIR;
                        end
                    end
                    CMD_STEP_OUT: begin
                        if (r_cur_track == 7'd0 && !TRACK0n) begin
                            w_next_state = S_FINISH;
                        end else begin
                            w_sdir_nxt   = 1'b0;
                            w_next_state = S_DIR;
                        end
                    end
                    default: begin
                        // RESTORE: a head already at track 0 finishes without moving, so no settle.
                        if (!TRACK0n) begin
                            w_track_nxt = 7'd0;
                            if (r_restore_cnt == 8'd0) begin
                                w_next_state = S_FINISH;
                            end else begin
                                w_next_state = S_SETTLE;
                                w_ms_cnt_nxt = LP_SETTLE;
                            end
                        end else if (r_restore_cnt == LP_LIMIT) begin
                            w_next_state = S_FINISH;
                            w_error_nxt  = 1'b1;
                        end else begin
                            w_sdir_nxt   = 1'b0;
                            w_next_state = S_DIR;
                        end
                    end
                endcase
            end
            S_DIR: begin
                w_next_state    = S_PULSE;
                w_pulse_cnt_nxt = LP_PULSE;
            end
            S_PULSE: begin
                if (r_pulse_cnt == 16'd0) begin
                    if (r_sdir) begin
                        w_track_nxt = r_cur_track + 7'd1;
                    end else if (r_cur_track != 7'd0) begin
                        w_track_nxt = r_cur_track - 7'd1;
                    end
                    if (r_cmd == CMD_RESTORE) begin
                        w_restore_cnt_nxt = r_restore_cnt + 8'd1;
                    end
                    w_next_state = S_STEP_WAIT;
                    w_ms_cnt_nxt = LP_STEP;
                end else begin
                    w_pulse_cnt_nxt = r_pulse_cnt - 16'd1;
                end
            end
            S_STEP_WAIT: begin
                if (r_ms_cnt == 16'd0) begin
                    if (r_cmd == CMD_RESTORE ||
                        (r_cmd == CMD_SEEK && r_cur_track != r_target)) begin
                        w_next_state = S_CHECK;
                    end else begin
                        w_next_state = S_SETTLE;
                        w_ms_cnt_nxt = LP_SETTLE;
                    end
                end else if (msclk) begin
                    w_ms_cnt_nxt = r_ms_cnt - 16'd1;
                end
            end
            S_SETTLE: begin
                if (r_ms_cnt == 16'd0) begin
                    w_next_state = S_FINISH;
                end else if (msclk) begin
                    w_ms_cnt_nxt = r_ms_cnt - 16'd1;
                end
            end
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // Abort discards any track update from the interrupted pulse; in FINISH it only flags the error
        // so done stays a single cycle.
        if (abort && r_state != S_IDLE) begin
            w_track_nxt       = r_cur_track;
            w_sdir_nxt        = r_sdir;
            w_restore_cnt_nxt = r_restore_cnt;
            w_error_nxt       = 1'b1;
            w_next_state      = (r_state == S_FINISH) ? S_IDLE : S_FINISH;
        end
    end

    assign cmd_ready = r_ready && (r_state == S_IDLE);
    assign STEPn     = (r_state != S_PULSE);
    assign SDIRn     = r_sdir;
    assign cur_track = r_cur_track;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FINISH);
    assign error     = r_error;

endmodule

// File: tb/tb_fdd_seek_ctrl.sv
// Self-checking bench for fdd_seek_ctrl: directed scenarios plus randomized commands against a track-level model.
module tb_fdd_seek_ctrl;

    localparam int STEP_MS    = 4;
    localparam int SETTLE_MS  = 15;
    localparam int PULSE_CLKS = 4;
    localparam int MS_DIV     = 6;
    localparam int TIMEOUT    = 6000;
    localparam logic [1:0] CMD_RESTORE  = 2'd0;
    localparam logic [1:0] CMD_SEEK     = 2'd1;
    localparam logic [1:0] CMD_STEP_IN  = 2'd2;
    localparam logic [1:0] CMD_STEP_OUT = 2'd3;

    logic       clk = 1'b0;
    logic       resetn, msclk, cmd_valid, abort, TRACK0n;
    logic [1:0] cmd;
    logic [6:0] target;
    logic       cmd_ready, STEPn, SDIRn, busy, done, error;
    logic [6:0] cur_track;

    int checks = 0;
    int errors = 0;
    int model_track = 0;

    int mon_starts = 0, mon_pulses = 0, mon_in = 0, mon_out = 0;
    int mon_badw = 0, mon_glitch = 0, mon_gapbad = 0, mon_done_ticks = -1;

    fdd_seek_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .msclk     (msclk),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .target    (target),
        .abort     (abort),
        .TRACK0n   (TRACK0n),
        .STEPn     (STEPn),
        .SDIRn     (SDIRn),
        .cur_track (cur_track),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    initial begin
        msclk = 1'b0;
        forever begin
            for (int k = 0; k < MS_DIV - 1; k++) begin
                @(posedge clk); #1; msclk = 1'b0;
            end
            @(posedge clk); #1; msclk = 1'b1;
        end
    end

    // Pulse monitor: width, direction stability, msclk spacing, and ticks from last pulse to done.
    initial begin
        bit in_low, had_pulse, pdir;
        int width, ticks;
        in_low = 0; had_pulse = 0; pdir = 0; width = 0; ticks = 0;
        forever begin
            @(negedge clk);
            if (cmd_valid === 1'b1 && cmd_ready === 1'b1) had_pulse = 0;
            if (STEPn === 1'b0) begin
                if (!in_low) begin
                    in_low = 1; width = 0; pdir = SDIRn; mon_starts++;
                    if (had_pulse && ticks < STEP_MS) mon_gapbad++;
                end
                width++;
                if (SDIRn !== pdir) mon_glitch++;
            end else if (in_low) begin
                in_low = 0; mon_pulses++; had_pulse = 1; ticks = 0;
                if (width != PULSE_CLKS) mon_badw++;
                if (pdir) mon_in++; else mon_out++;
            end
            if (done === 1'b1) mon_done_ticks = had_pulse ? ticks : -1;
            if (msclk === 1'b1) ticks++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_cmd(input logic [1:0] c, input logic [6:0] t, input int t0_after, output int lat);
        int n, p0;
        bit got;
        TRACK0n = (t0_after == 0) ? 1'b0 : 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        p0 = mon_pulses;
        cmd_valid = 1'b1; cmd = c; target = t;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0; got = 0;
        while (!got && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
            if (t0_after > 0 && (mon_pulses - p0) >= t0_after) TRACK0n = 1'b0;
            if (done === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL cmd_timeout cmd=%0d target=%0d: no done within %0d clks", c, t, TIMEOUT);
        end
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; cmd_valid = 1'b0; cmd = 2'd0; target = 7'd0; abort = 1'b0; TRACK0n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (STEPn !== 1'b1 || SDIRn !== 1'b0 || cur_track !== 7'd0 || busy !== 1'b0 ||
            done !== 1'b0 || error !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got STEPn=%b SDIRn=%b trk=%0d busy=%b done=%b err=%b rdy=%b, want 1 0 0 0 0 0 0",
                     STEPn, SDIRn, cur_track, busy, done, error, cmd_ready);
        end
        @(posedge clk); #1; resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL ready_before_clk got %b want 0", cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_clk got %b want 1", cmd_ready);
        end
        model_track = 0;
    endtask

    task automatic test_seek_basic();
        int lat, p0, i0, b0, g0, gl0;
        p0 = mon_pulses; i0 = mon_in; b0 = mon_badw; g0 = mon_gapbad; gl0 = mon_glitch;
        run_cmd(CMD_SEEK, 7'd3, -1, lat);
        checks++;
        if (mon_pulses - p0 != 3 || mon_in - i0 != 3) begin
            errors++; $display("FAIL seek3_pulses got %0d (in %0d) want 3 (in 3)", mon_pulses - p0, mon_in - i0);
        end
        checks++;
        if (mon_badw != b0 || mon_glitch != gl0 || mon_gapbad != g0) begin
            errors++; $display("FAIL seek3_timing badwidth=%0d glitch=%0d gap=%0d want 0 0 0",
                               mon_badw - b0, mon_glitch - gl0, mon_gapbad - g0);
        end
        checks++;
        if (mon_done_ticks != STEP_MS + SETTLE_MS) begin
            errors++; $display("FAIL seek3_settle ticks got %0d want %0d", mon_done_ticks, STEP_MS + SETTLE_MS);
        end
        checks++;
        if (cur_track !== 7'd3 || error !== 1'b0) begin
            errors++; $display("FAIL seek3_result trk=%0d err=%b want 3 0", cur_track, error);
        end
        model_track = 3;
    endtask

    task automatic test_seek_same();
        int lat, p0;
        p0 = mon_pulses;
        run_cmd(CMD_SEEK, 7'd3, -1, lat);
        checks++;
        if (lat > 3 || mon_pulses != p0 || cur_track !== 7'd3 || error !== 1'b0) begin
            errors++; $display("FAIL seek_same lat=%0d pulses=%0d trk=%0d err=%b want <=3 0 3 0",
                               lat, mon_pulses - p0, cur_track, error);
        end
    endtask

    task automatic test_seek_illegal();
        int lat, p0;
        p0 = mon_pulses;
        run_cmd(CMD_SEEK, 7'd81, -1, lat);
        checks++;
        if (mon_pulses != p0 || cur_track !== 7'd3 || error !== 1'b1) begin
            errors++; $display("FAIL seek81 pulses=%0d trk=%0d err=%b want 0 3 1", mon_pulses - p0, cur_track, error);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL error_hold err=%b busy=%b want 1 0", error, busy);
        end
    endtask

    task automatic test_step_in_max();
        int lat, p0;
        p0 = mon_pulses;
        run_cmd(CMD_SEEK, 7'd80, -1, lat);
        checks++;
        if (mon_pulses - p0 != 77 || cur_track !== 7'd80 || error !== 1'b0) begin
            errors++; $display("FAIL seek80 pulses=%0d trk=%0d err=%b want 77 80 0", mon_pulses - p0, cur_track, error);
        end
        p0 = mon_pulses;
        run_cmd(CMD_STEP_IN, 7'd0, -1, lat);
        checks++;
        if (mon_pulses != p0 || cur_track !== 7'd80 || error !== 1'b1) begin
            errors++; $display("FAIL step_in_max pulses=%0d trk=%0d err=%b want 0 80 1", mon_pulses - p0, cur_track, error);
        end
        model_track = 80;
    endtask

    task automatic test_restore_track0();
        int lat, p0, o0;
        p0 = mon_pulses; o0 = mon_out;
        run_cmd(CMD_RESTORE, 7'd0, 5, lat);
        checks++;
        if (mon_pulses - p0 != 5 || mon_out - o0 != 5 || cur_track !== 7'd0 || error !== 1'b0) begin
            errors++; $display("FAIL restore5 pulses=%0d out=%0d trk=%0d err=%b want 5 5 0 0",
                               mon_pulses - p0, mon_out - o0, cur_track, error);
        end
        checks++;
        if (mon_done_ticks != STEP_MS + SETTLE_MS) begin
            errors++; $display("FAIL restore5_settle ticks got %0d want %0d", mon_done_ticks, STEP_MS + SETTLE_MS);
        end
        p0 = mon_pulses;
        run_cmd(CMD_RESTORE, 7'd0, 0, lat);
        checks++;
        if (lat > 3 || mon_pulses != p0 || cur_track !== 7'd0 || error !== 1'b0) begin
            errors++; $display("FAIL restore_at0 lat=%0d pulses=%0d trk=%0d err=%b want <=3 0 0 0",
                               lat, mon_pulses - p0, cur_track, error);
        end
        p0 = mon_pulses;
        run_cmd(CMD_STEP_OUT, 7'd0, 0, lat);
        checks++;
        if (mon_pulses != p0 || cur_track !== 7'd0 || error !== 1'b0) begin
            errors++; $display("FAIL step_out_at0 pulses=%0d trk=%0d err=%b want 0 0 0", mon_pulses - p0, cur_track, error);
        end
        model_track = 0;
    endtask

    task automatic test_restore_stuck();
        int lat, p0, o0;
        p0 = mon_pulses; o0 = mon_out;
        run_cmd(CMD_RESTORE, 7'd0, -1, lat);
        checks++;
        if (mon_pulses - p0 != 84 || mon_out - o0 != 84 || cur_track !== 7'd0 || error !== 1'b1) begin
            errors++; $display("FAIL restore_stuck pulses=%0d out=%0d trk=%0d err=%b want 84 84 0 1",
                               mon_pulses - p0, mon_out - o0, cur_track, error);
        end
    endtask

    task automatic test_abort();
        int n, starts;
        logic prev;
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b1) begin
            errors++; $display("FAIL abort_idle busy=%b done=%b err=%b want 0 0 1", busy, done, error);
        end
        TRACK0n = 1'b1;
        @(posedge clk); #1; cmd_valid = 1'b1; cmd = CMD_SEEK; target = 7'd5;
        @(posedge clk); #1; cmd_valid = 1'b0;
        starts = 0; prev = 1'b1; n = 0;
        while (starts < 2 && n < 500) begin
            @(negedge clk);
            if (prev === 1'b1 && STEPn === 1'b0) starts++;
            prev = STEPn; n++;
        end
        checks++;
        if (starts < 2) begin
            errors++; $display("FAIL abort_wait saw %0d pulses want 2", starts);
        end
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        checks++;
        if (STEPn !== 1'b1 || done !== 1'b1 || error !== 1'b1 || cur_track !== 7'd1) begin
            errors++; $display("FAIL abort_pulse STEPn=%b done=%b err=%b trk=%0d want 1 1 1 1",
                               STEPn, done, error, cur_track);
        end
        @(posedge clk); #1;
        model_track = 1;
    endtask

    task automatic test_reset_midwait();
        int n, lat, p0;
        TRACK0n = 1'b1;
        @(posedge clk); #1; cmd_valid = 1'b1; cmd = CMD_SEEK; target = 7'd10;
        @(posedge clk); #1; cmd_valid = 1'b0;
        n = 0;
        while (STEPn !== 1'b0 && n < 300) begin @(posedge clk); #1; n++; end
        while (STEPn !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        checks++;
        if (n >= 300) begin
            errors++; $display("FAIL midwait_pulse no pulse within 300 clks");
        end
        repeat (5) @(posedge clk);
        #3; resetn = 1'b0; #1;
        checks++;
        if (STEPn !== 1'b1 || SDIRn !== 1'b0 || cur_track !== 7'd0 || busy !== 1'b0 ||
            done !== 1'b0 || error !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_wait STEPn=%b SDIRn=%b trk=%0d busy=%b done=%b err=%b rdy=%b want 1 0 0 0 0 0 0",
                     STEPn, SDIRn, cur_track, busy, done, error, cmd_ready);
        end
        @(posedge clk); #1; resetn = 1'b1;
        @(posedge clk); #1; cmd_valid = 1'b1; cmd = CMD_SEEK; target = 7'd5;
        @(posedge clk); #1; cmd_valid = 1'b0;
        n = 0;
        while (STEPn !== 1'b0 && n < 300) begin @(posedge clk); #1; n++; end
        #2; resetn = 1'b0; #1;
        checks++;
        if (STEPn !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_in_pulse STEPn=%b busy=%b want 1 0", STEPn, busy);
        end
        @(posedge clk); #1; resetn = 1'b1;
        p0 = mon_pulses;
        run_cmd(CMD_SEEK, 7'd2, -1, lat);
        checks++;
        if (mon_pulses - p0 != 2 || cur_track !== 7'd2 || error !== 1'b0) begin
            errors++; $display("FAIL after_reset_seek pulses=%0d trk=%0d err=%b want 2 2 0",
                               mon_pulses - p0, cur_track, error);
        end
        model_track = 2;
    endtask

    task automatic test_random();
        int c, t, lat, p0, i0, exp_p, exp_in, exp_err;
        for (int i = 0; i < 10; i++) begin
            c = int'($urandom_range(0, 3));
            t = ($urandom_range(0, 7) == 0) ? int'($urandom_range(81, 127)) : int'($urandom_range(0, 12));
            exp_err = 0; exp_p = 0; exp_in = 0;
            case (c)
                1: begin
                    if (t > 80) exp_err = 1;
                    else begin
                        exp_p  = (t > model_track) ? t - model_track : model_track - t;
                        exp_in = (t > model_track) ? exp_p : 0;
                        model_track = t;
                    end
                end
                2: begin
                    if (model_track == 80) exp_err = 1;
                    else begin exp_p = 1; exp_in = 1; model_track++; end
                end
                3: begin
                    if (model_track != 0) begin exp_p = 1; model_track--; end
                end
                default: begin
                    exp_p = model_track; model_track = 0;
                end
            endcase
            p0 = mon_pulses; i0 = mon_in;
            run_cmd(2'(c), 7'(t), (c == 0 || c == 3) ? exp_p : 0, lat);
            checks++;
            if (mon_pulses - p0 != exp_p || mon_in - i0 != exp_in) begin
                errors++; $display("FAIL rand%0d_pulses cmd=%0d tgt=%0d got %0d (in %0d) want %0d (in %0d)",
                                   i, c, t, mon_pulses - p0, mon_in - i0, exp_p, exp_in);
            end
            checks++;
            if (cur_track !== 7'(model_track) || error !== 1'(exp_err)) begin
                errors++; $display("FAIL rand%0d_result cmd=%0d tgt=%0d trk=%0d err=%b want %0d %0d",
                                   i, c, t, cur_track, error, model_track, exp_err);
            end
            if (exp_p > 0) begin
                checks++;
                if (mon_done_ticks != STEP_MS + SETTLE_MS) begin
                    errors++; $display("FAIL rand%0d_settle ticks got %0d want %0d", i, mon_done_ticks, STEP_MS + SETTLE_MS);
                end
            end
        end
    endtask

    initial begin
        resetn = 1'b0; cmd_valid = 1'b0; cmd = 2'd0; target = 7'd0; abort = 1'b0; TRACK0n = 1'b1;
        test_reset();
        test_seek_basic();
        test_seek_same();
        test_seek_illegal();
        test_step_in_max();
        test_restore_track0();
        test_restore_stuck();
        test_abort();
        test_reset_midwait();
        test_random();
        checks++;
        if (mon_glitch != 0) begin
            errors++; $display("FAIL sdir_during_pulse changes=%0d want 0", mon_glitch);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fdd_seek_ctrl.md
FDD_SEEK_CTRL -- requirements
Module: fdd_seek_ctrl

Interface
REQ-001 SHALL have parameters: STEP_MS, default 4, msclk ticks waited after each step pulse; SETTLE_MS, default 15, msclk ticks of head settle after the last step; PULSE_CLKS, default 4, STEPn low width in clk cycles; MAX_TRACKS, default 80, highest legal track number; RESTORE_LIMIT, default 84, maximum steps for RESTORE.
REQ-002 SHALL have ports, one per line:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- msclk  in  1  one-clk pulse every 1 ms
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd  in  2  command code: 0 RESTORE, 1 SEEK, 2 STEP_IN, 3 STEP_OUT
- target  in  7  SEEK destination track
- abort  in  1  terminate the running command
- TRACK0n  in  1  drive track-0 sense, active low
- STEPn  out  1  step strobe to drive, active low
- SDIRn  out  1  direction: 1 = in (track+1), 0 = out
- cur_track  out  7  controller track register
- busy  out  1  state != IDLE
- done  out  1  one-clk completion pulse
- error  out  1  result flag; valid from done, held until next accepted command

Function
REQ-003 Acceptance SHALL occur on cmd_valid & cmd_ready; cmd and target are latched on that clk; while busy, cmd_valid SHALL be ignored.
REQ-004 States SHALL be IDLE, CHECK, DIR, PULSE, STEP_WAIT, SETTLE, FINISH.
REQ-005 IDLE -> CHECK on acceptance; error SHALL clear on that clk.
REQ-006 CHECK SHALL decide the next step in one clk, as follows.
- SEEK: target > MAX_TRACKS -> FINISH with error=1; target == cur_track -> FINISH; otherwise direction = (target > cur_track), then DIR.
- STEP_IN: cur_track == MAX_TRACKS -> FINISH with error=1; otherwise DIR with SDIRn=1.
- STEP_OUT: cur_track == 0 and TRACK0n == 0 -> FINISH with no pulse; otherwise DIR with SDIRn=0.
- RESTORE: TRACK0n == 0 -> cur_track <= 0, then FINISH, with no pulse when this holds at the first CHECK; step count == RESTORE_LIMIT -> FINISH with error=1 and cur_track unchanged; otherwise DIR with SDIRn=0.
REQ-007 DIR SHALL hold SDIRn stable with STEPn high for exactly 1 clk, then enter PULSE.
REQ-008 PULSE SHALL drive STEPn low for exactly PULSE_CLKS clks.
REQ-009 On leaving PULSE, cur_track SHALL be updated: +1 when SDIRn=1; -1 when SDIRn=0, saturating at 0.
REQ-010 RESTORE SHALL increment an 8-bit step counter on each pulse; the counter SHALL clear on acceptance.
REQ-011 STEP_WAIT SHALL load a counter with STEP_MS, decrement it on each msclk, and exit when it reaches 0.
REQ-012 On exit from STEP_WAIT, the next state SHALL be chosen as follows.
- SEEK: return to CHECK; when cur_track == target, go to SETTLE instead.
- RESTORE: return to CHECK.
- STEP_IN / STEP_OUT: go to SETTLE.
REQ-013 SETTLE SHALL wait SETTLE_MS msclk ticks using the same counter rule, then enter FINISH.
REQ-014 RESTORE termination via CHECK after at least one pulse SHALL also pass through SETTLE.
REQ-015 FINISH SHALL assert done for 1 clk and return to IDLE.
REQ-016 SDIRn SHALL change only in CHECK/DIR, never while STEPn is low.
REQ-017 abort in any non-IDLE state SHALL, on the next clk, force STEPn high, go to FINISH with error=1, and leave cur_track unchanged by the interrupted pulse; abort in IDLE SHALL be ignored.
REQ-018 Simultaneous msclk and a state change into STEP_WAIT/SETTLE SHALL load the counter without decrementing on that tick.

Reset
REQ-019 While resetn=0: state=IDLE, STEPn=1, SDIRn=0, cur_track=0, busy=0, done=0, error=0, cmd_ready=0; internal counters=0.
REQ-020 cmd_ready SHALL rise on the first clk after resetn deasserts.
REQ-021 Reset asserted mid-pulse SHALL return STEPn high asynchronously.

Verification
REQ-022 The bench SHALL cover these scenarios.
- SEEK target=3 from cur_track 0 -> exactly 3 STEPn pulses of 4 clks each, SDIRn=1, pulses ≥4 msclk ticks apart; done after 15 further ticks; cur_track=3; error=0.
- SEEK target=3 from cur_track 3 -> done within 3 clks of acceptance, no pulse.
- RESTORE with TRACK0n forced low after 5 pulses -> 5 pulses with SDIRn=0, cur_track=0, error=0.
- RESTORE with TRACK0n stuck high -> 84 pulses, then done with error=1.
- SEEK target=81 -> done with error=1, no pulse.
- STEP_IN at cur_track 80 -> error=1.
- abort during the 2nd PULSE -> STEPn high next clk, done with error=1, cur_track=1.
- resetn low during STEP_WAIT -> all outputs at reset values; a new command is accepted afterwards.
